nibble_serial_add_ctrl: RTL

Sequencer that performs wide multi-precision additions by time-multiplexing one 4-bit ripple-carry adder cell, one nibble per clock, least-significant nibble first. The inter-nibble carry is held in a register. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It trades latency for area in wide datapaths that cannot afford a full-width adder.

---
 rtl/nibble_serial_add_ctrl_if.sv | 43 ++++
 rtl/nibble_serial_add_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl_if
// Brief    : Operand/result valid-ready bundle for nibble_serial_add_ctrl.
//            in_sub exists only when NSA_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef NSA_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
`ifdef NSA_SUB_EN
        , input in_sub
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
`ifdef NSA_SUB_EN
        , output in_sub
`endif
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : Multi-precision adder reusing one 4-bit cell, LS nibble first.
//            Define NSA_SUB_EN to add the subtract (A-B) mode.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    nibble_serial_add_ctrl_if.slave      bus,
    output logic                         busy
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] C_LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_cin;
    logic              r_carry;
    logic              r_ovf;
    logic [IDXW-1:0]   r_idx;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic              w_accept;
    logic              w_last;
    logic [IDXW+1:0]   w_base;
    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic              w_cell_cin;
    logic [3:0]        w_lo;
    logic              w_c3;
    logic [3:0]        w_s;
    logic              w_co;
    logic              w_cin_latch;

    assign w_accept = r_in_ready & bus.in_valid;
    assign w_last   = (r_idx == C_LAST);
    assign w_base   = {r_idx, 2'b00};
    assign w_a_nib  = r_a[w_base +: 4];

`ifdef NSA_SUB_EN
    logic r_sub;
    // Subtraction is A + ~B + 1, so the initial carry is forced high.
    assign w_b_nib     = r_sub ? ~r_b[w_base +: 4] : r_b[w_base +: 4];
    assign w_cin_latch = bus.in_sub | bus.in_cin;
`else
    assign w_b_nib     = r_b[w_base +: 4];
    assign w_cin_latch = bus.in_cin;
`endif

    // Cell split at bit 3 so the carry into the MSB is visible for overflow.
    assign w_cell_cin = (r_idx == '0) ? r_cin : r_carry;
    assign w_lo = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, w_cell_cin};
    assign w_c3 = w_lo[3];
    assign w_s  = {w_a_nib[3] ^ w_b_nib[3] ^ w_c3, w_lo[2:0]};
    assign w_co = (w_a_nib[3] & w_b_nib[3]) | (w_a_nib[3] & w_c3) | (w_b_nib[3] & w_c3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)      w_state_next = S_RUN;
            S_RUN:   if (w_last)        w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
`ifdef NSA_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_cin   <= w_cin_latch;
                        r_sum   <= '0;
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_idx   <= '0;
`ifdef NSA_SUB_EN
                        r_sub   <= bus.in_sub;
`endif
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 4] <= w_s;
                    r_carry            <= w_co;
                    r_idx              <= r_idx + 1'b1;
                    if (w_last) r_ovf  <= w_c3 ^ w_co;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state to keep them flop-driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_carry;
    assign bus.out_ovf   = r_ovf;
    assign busy          = r_busy;
endmodule
`default_nettype wire
